piece_control: RTL and testbench
================================

Name: piece_control

Overview:
- Control FSM directly upstream of the border/position register stage.
- Reads the registered column borders (border) and the four cell coordinates of the active piece (rho_x, rho_y).
- Accepts gravity and lateral move commands, checks each candidate move against the borders and the field walls, and drives new_border, new_rho_x, new_rho_y, write_reg, is_load_fig and figure back into that stage.
- Sequences spawn, move, land and game-over.

Parameters:
MEM_WIDTH, 10, number of field columns
MEM_HEIGHT, 20, field height (informative; the floor is carried in border reset values)
WIDTH, 8, bit width of each coordinate and border entry

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
tick  input  1  gravity request (one-cycle pulse)
cmd_left  input  1  move-left request
cmd_right  input  1  move-right request
border  input  MEM_WIDTH*WIDTH  per-column smallest occupied y; column 0 in the MSB slice
rho_x  input  4*WIDTH  cell x coords; cell 0 in the MSB slice
rho_y  input  4*WIDTH  cell y coords; same ordering as rho_x
new_border  output  MEM_WIDTH*WIDTH  next border
new_rho_x  output  4*WIDTH  next x coords
new_rho_y  output  4*WIDTH  next y coords
write_reg  output  1  load strobe for the register stage
is_load_fig  output  1  spawn strobe; register stage loads spawn coords for figure
figure  output  WIDTH  current figure id: 0=T, 1=Q, 2=I
cmd_ack  output  1  one-cycle pulse when a request is accepted
game_over  output  1  sticky game-over flag
pieces  output  16  count of landed pieces

Behaviour:
- Reset: clk and rst are fixed — one clock, synchronous active-high reset.
- While rst is high, all strobes and flags are forced low: write_reg=0, is_load_fig=0, cmd_ack=0, game_over=0.
- Registers after reset: state=SPAWN, figure=0, pieces=0, cmd_r=NONE.
- Default pass-through: new_border=border, new_rho_x=rho_x, new_rho_y=rho_y whenever not overridden below.
- Geometry: y grows downward. Cell (x,y) is legal iff x<MEM_WIDTH and y<border[x].
- All comparisons are unsigned WIDTH-bit. x-1 is evaluated only when x>0.
- FSM states and transitions:
  - SPAWN: is_load_fig=1 for exactly one cycle -> CHECK.
  - CHECK: one cycle; coordinates now reflect the spawn values.
    - If any cell has y>=border[x] -> OVER.
    - Otherwise -> READY.
  - READY: accepts at most one request per cycle, priority tick > cmd_left > cmd_right.
    - Requests that lose arbitration are dropped, not queued.
    - On acceptance: cmd_ack=1, latch cmd_r -> EVAL.
    - With no request, stay in READY.
  - EVAL: one cycle; evaluate cmd_r.
    - LEFT is legal iff every cell has x>0 and y<border[x-1]. If legal: write_reg=1, new_rho_x=x-1 for all cells. Either way -> READY.
    - RIGHT is legal iff every cell has x<MEM_WIDTH-1 and y<border[x+1]. If legal: write_reg=1, new_rho_x=x+1. Either way -> READY.
    - DOWN is legal iff every cell has y+1<border[x]. If legal: write_reg=1, new_rho_y=y+1 -> READY. If illegal -> LAND.
    - An illegal move produces no write_reg and no coordinate change.
  - LAND: one cycle; write_reg=1.
    - For each column c: new_border[c] = min(border[c], min y over cells with x==c).
    - new_rho is unchanged.
    - figure <= (figure==2) ? 0 : figure+1.
    - pieces <= pieces+1, wrapping at 2^16.
    - -> SPAWN.
  - OVER: game_over=1. Stay in OVER, ignore all requests, no strobes, until rst.
- write_reg and is_load_fig are never asserted in the same cycle.
- Requests arriving in any state other than READY are ignored.
- rst asserted in any state returns the FSM to SPAWN on the next edge. No partial write is issued in that cycle.
- Move latency: request in READY -> write_reg in the next cycle -> coordinates updated in the cycle after. The next request is accepted no earlier than 2 cycles after the previous one.

Test Plan:
- Spawn T: rst, all borders 6 -> after SPAWN/CHECK, coords (0,0),(1,0),(2,0),(1,1); game_over=0; state READY.
- Left wall: T at x 0..2; cmd_left -> cmd_ack=1, no write_reg in EVAL, coords unchanged.
- Right wall: 7 cmd_right pulses spaced 3 cycles -> max x=9; 8th cmd_right is acked with no write_reg.
- Simultaneous: tick and cmd_left in the same READY cycle -> only DOWN applied (y+1); the left request is lost.
- T landing: borders 6, T at spawn; 4 ticks -> cells at y 4,4,4,5; 5th tick -> LAND, new_border[0..2]=4, others 6; pieces=1; figure=1; is_load_fig pulses.
- Game over: continue from the previous scenario. Q spawns (0,0),(1,0),(0,1),(0,2); tick -> y+1; tick -> LAND with border[0]=1, border[1]=1. I then spawns at x=0, y 0..3 -> CHECK finds 1>=1 -> game_over=1. Further ticks are ignored; rst clears the flag.

Source files
------------

// File: rtl/piece_control.sv
// Piece control FSM: spawns, moves and lands the active piece by driving the
// border/position register stage that sits directly downstream.
module piece_control #(
  parameter int MEM_WIDTH  = 10,
  parameter int MEM_HEIGHT = 20,
  parameter int WIDTH      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick,
  input  logic                       cmd_left,
  input  logic                       cmd_right,
  input  logic [MEM_WIDTH*WIDTH-1:0] border,
  input  logic [4*WIDTH-1:0]         rho_x,
  input  logic [4*WIDTH-1:0]         rho_y,
  output logic [MEM_WIDTH*WIDTH-1:0] new_border,
  output logic [4*WIDTH-1:0]         new_rho_x,
  output logic [4*WIDTH-1:0]         new_rho_y,
  output logic                       write_reg,
  output logic                       is_load_fig,
  output logic [WIDTH-1:0]           figure,
  output logic                       cmd_ack,
  output logic                       game_over,
  output logic [15:0]                pieces
);

  typedef enum logic [2:0] {S_SPAWN, S_CHECK, S_READY, S_EVAL, S_LAND, S_OVER} state_t;
  typedef enum logic [1:0] {C_NONE, C_DOWN, C_LEFT, C_RIGHT} cmd_t;

  state_t      state_q, state_d;
  cmd_t        cmd_q, cmd_d;
  logic [1:0]  figure_q, figure_d;
  logic [15:0] pieces_q, pieces_d;

  logic [WIDTH-1:0]           bcol [MEM_WIDTH];
  logic [WIDTH-1:0]           cx [4];
  logic [WIDTH-1:0]           cy [4];
  logic [3:0]                 here_ok, left_ok, right_ok, down_ok;
  logic [4*WIDTH-1:0]         rho_x_left, rho_x_right, rho_y_down;
  logic [MEM_WIDTH*WIDTH-1:0] land_border;

  genvar gi;

  // The floor row index must be representable in a coordinate.
  if (MEM_HEIGHT >= (1 << WIDTH)) begin : g_height_check
    $error("piece_control: MEM_HEIGHT does not fit in WIDTH bits");
  end

  for (gi = 0; gi < MEM_WIDTH; gi++) begin : g_col
    logic [WIDTH-1:0] col_min;
    assign bcol[gi] = border[(MEM_WIDTH-1-gi)*WIDTH +: WIDTH];
    always_comb begin
      col_min = bcol[gi];
      for (int i = 0; i < 4; i++) begin
        if (cx[i] == WIDTH'(gi) && cy[i] < col_min) col_min = cy[i];
      end
    end
    assign land_border[(MEM_WIDTH-1-gi)*WIDTH +: WIDTH] = col_min;
  end

  for (gi = 0; gi < 4; gi++) begin : g_cell
    logic [WIDTH-1:0] b_at, b_left, b_right;
    assign cx[gi] = rho_x[(3-gi)*WIDTH +: WIDTH];
    assign cy[gi] = rho_y[(3-gi)*WIDTH +: WIDTH];
    // Out-of-field columns match no entry and read as border 0, i.e. illegal.
    always_comb begin
      b_at    = '0;
      b_left  = '0;
      b_right = '0;
      for (int c = 0; c < MEM_WIDTH; c++) begin
        if (cx[gi] == WIDTH'(c))              b_at    = bcol[c];
        if (cx[gi] == WIDTH'(c + 1))          b_left  = bcol[c];
        if (cx[gi] + WIDTH'(1) == WIDTH'(c))  b_right = bcol[c];
      end
    end
    assign here_ok[gi]  = cy[gi] < b_at;
    assign left_ok[gi]  = (cx[gi] != '0) && (cy[gi] < b_left);
    assign right_ok[gi] = (cx[gi] < WIDTH'(MEM_WIDTH - 1)) && (cy[gi] < b_right);
    assign down_ok[gi]  = ({1'b0, cy[gi]} + {{WIDTH{1'b0}}, 1'b1}) < {1'b0, b_at};
    assign rho_x_left[(3-gi)*WIDTH +: WIDTH]  = cx[gi] - WIDTH'(1);
    assign rho_x_right[(3-gi)*WIDTH +: WIDTH] = cx[gi] + WIDTH'(1);
    assign rho_y_down[(3-gi)*WIDTH +: WIDTH]  = cy[gi] + WIDTH'(1);
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    figure_d    = figure_q;
    pieces_d    = pieces_q;
    write_reg   = 1'b0;
    is_load_fig = 1'b0;
    cmd_ack     = 1'b0;
    game_over   = 1'b0;
    new_border  = border;
    new_rho_x   = rho_x;
    new_rho_y   = rho_y;
    case (state_q)
      S_SPAWN: begin
        is_load_fig = 1'b1;
        state_d     = S_CHECK;
      end
      S_CHECK: state_d = (&here_ok) ? S_READY : S_OVER;
      S_READY: begin
        if (tick) begin
          cmd_ack = 1'b1;
          cmd_d   = C_DOWN;
          state_d = S_EVAL;
        end else if (cmd_left) begin
          cmd_ack = 1'b1;
          cmd_d   = C_LEFT;
          state_d = S_EVAL;
        end else if (cmd_right) begin
          cmd_ack = 1'b1;
          cmd_d   = C_RIGHT;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        state_d = S_READY;
        cmd_d   = C_NONE;
        case (cmd_q)
          C_LEFT: if (&left_ok) begin
            write_reg = 1'b1;
            new_rho_x = rho_x_left;
          end
          C_RIGHT: if (&right_ok) begin
            write_reg = 1'b1;
            new_rho_x = rho_x_right;
          end
          C_DOWN: if (&down_ok) begin
            write_reg = 1'b1;
            new_rho_y = rho_y_down;
          end else begin
            state_d = S_LAND;
          end
          default: ;
        endcase
      end
      S_LAND: begin
        write_reg  = 1'b1;
        new_border = land_border;
        figure_d   = (figure_q == 2'd2) ? 2'd0 : figure_q + 2'd1;
        pieces_d   = pieces_q + 16'd1;
        state_d    = S_SPAWN;
      end
      S_OVER:  game_over = 1'b1;
      default: state_d = S_SPAWN;
    endcase
    // Strobes are suppressed during reset regardless of the current state.
    if (rst) begin
      write_reg   = 1'b0;
      is_load_fig = 1'b0;
      cmd_ack     = 1'b0;
      game_over   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_SPAWN;
      cmd_q    <= C_NONE;
      figure_q <= 2'd0;
      pieces_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      figure_q <= figure_d;
      pieces_q <= pieces_d;
    end
  end

  assign figure = {{(WIDTH-2){1'b0}}, figure_q};
  assign pieces = pieces_q;

endmodule

// File: tb/tb_piece_control.sv
// Bench for piece_control: models the downstream register stage, predicts every
// output each cycle from the game rules, and runs the directed scenarios.
module tb_piece_control;
  localparam int MW = 10;
  localparam int W  = 8;
  localparam int P_SPAWN = 0, P_CHECK = 1, P_READY = 2, P_EVAL = 3, P_LAND = 4, P_OVER = 5;
  localparam int R_NONE = 0, R_DOWN = 1, R_LEFT = 2, R_RIGHT = 3;

  logic clk = 1'b0, rst = 1'b1, tick = 1'b0, cmd_left = 1'b0, cmd_right = 1'b0;
  logic [MW*W-1:0] border, new_border;
  logic [4*W-1:0]  rho_x, rho_y, new_rho_x, new_rho_y;
  logic            write_reg, is_load_fig, cmd_ack, game_over;
  logic [W-1:0]    figure;
  logic [15:0]     pieces;

  int st_border [MW];
  int st_x [4];
  int st_y [4];

  int n_cmp = 0, n_fail = 0;
  int ack_cnt = 0, wr_cnt = 0, ld_cnt = 0;
  int m_phase = P_SPAWN, m_req = R_NONE, m_fig = 0, m_pieces = 0;
  bit m_valid = 1'b0;

  int n_phase, n_req, n_fig, n_pieces, dx, dy;
  bit e_wr, e_ld, e_ack, e_go;
  int e_b [MW];
  int e_x [4];
  int e_y [4];
  logic [MW*W-1:0] e_nb;
  logic [4*W-1:0]  e_nx, e_ny;
  int a0, w0, l0;

  always #5 clk = ~clk;

  piece_control #(.MEM_WIDTH(MW), .MEM_HEIGHT(20), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .tick(tick), .cmd_left(cmd_left), .cmd_right(cmd_right),
    .border(border), .rho_x(rho_x), .rho_y(rho_y),
    .new_border(new_border), .new_rho_x(new_rho_x), .new_rho_y(new_rho_y),
    .write_reg(write_reg), .is_load_fig(is_load_fig), .figure(figure),
    .cmd_ack(cmd_ack), .game_over(game_over), .pieces(pieces)
  );

  function automatic int spawn_x(int f, int i);
    case (f)
      0:       return (i == 3) ? 1 : i;
      1:       return (i == 1) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic int spawn_y(int f, int i);
    case (f)
      0:       return (i == 3) ? 1 : 0;
      1:       return (i < 2) ? 0 : i - 1;
      default: return i;
    endcase
  endfunction

  // Does the whole piece, shifted by (sx,sy), sit inside the walls and above the borders?
  function automatic bit fits(int sx, int sy);
    int nx, ny;
    for (int i = 0; i < 4; i++) begin
      nx = st_x[i] + sx;
      ny = st_y[i] + sy;
      if (nx < 0 || nx >= MW) return 1'b0;
      if (ny >= st_border[nx]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic chk_cells(input string name, input int x0, input int x1, input int x2,
                           input int x3, input int y0, input int y1, input int y2, input int y3);
    int ex [4];
    int ey [4];
    ex = '{x0, x1, x2, x3};
    ey = '{y0, y1, y2, y3};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_x%0d", name, i), st_x[i], ex[i]);
      chk($sformatf("%s_y%0d", name, i), st_y[i], ey[i]);
    end
  endtask

  // Register stage fed by the DUT.
  always @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < MW; c++) st_border[c] <= 6;
      for (int i = 0; i < 4; i++) begin
        st_x[i] <= 0;
        st_y[i] <= 0;
      end
    end else if (write_reg) begin
      for (int c = 0; c < MW; c++) st_border[c] <= int'(new_border[(MW-1-c)*W +: W]);
      for (int i = 0; i < 4; i++) begin
        st_x[i] <= int'(new_rho_x[(3-i)*W +: W]);
        st_y[i] <= int'(new_rho_y[(3-i)*W +: W]);
      end
    end else if (is_load_fig) begin
      for (int i = 0; i < 4; i++) begin
        st_x[i] <= spawn_x(int'(figure), i);
        st_y[i] <= spawn_y(int'(figure), i);
      end
    end
  end

  always_comb begin
    border = '0;
    rho_x  = '0;
    rho_y  = '0;
    for (int c = 0; c < MW; c++) border[(MW-1-c)*W +: W] = W'(st_border[c]);
    for (int i = 0; i < 4; i++) begin
      rho_x[(3-i)*W +: W] = W'(st_x[i]);
      rho_y[(3-i)*W +: W] = W'(st_y[i]);
    end
  end

  // Reference model and per-cycle comparison.
  always @(negedge clk) begin
    if (rst || m_valid) begin
      e_wr = 1'b0; e_ld = 1'b0; e_ack = 1'b0; e_go = 1'b0;
      for (int c = 0; c < MW; c++) e_b[c] = st_border[c];
      for (int i = 0; i < 4; i++) begin
        e_x[i] = st_x[i];
        e_y[i] = st_y[i];
      end
      n_phase = m_phase; n_req = m_req; n_fig = m_fig; n_pieces = m_pieces;
      if (rst) begin
        n_phase = P_SPAWN; n_req = R_NONE; n_fig = 0; n_pieces = 0;
      end else begin
        case (m_phase)
          P_SPAWN: begin e_ld = 1'b1; n_phase = P_CHECK; end
          P_CHECK: n_phase = fits(0, 0) ? P_READY : P_OVER;
          P_READY: if (tick || cmd_left || cmd_right) begin
            e_ack   = 1'b1;
            n_phase = P_EVAL;
            n_req   = tick ? R_DOWN : (cmd_left ? R_LEFT : R_RIGHT);
          end
          P_EVAL: begin
            dx = (m_req == R_LEFT) ? -1 : ((m_req == R_RIGHT) ? 1 : 0);
            dy = (m_req == R_DOWN) ? 1 : 0;
            n_phase = P_READY;
            if (fits(dx, dy)) begin
              e_wr = 1'b1;
              for (int i = 0; i < 4; i++) begin
                e_x[i] = st_x[i] + dx;
                e_y[i] = st_y[i] + dy;
              end
            end else if (m_req == R_DOWN) begin
              n_phase = P_LAND;
            end
          end
          P_LAND: begin
            e_wr = 1'b1;
            for (int i = 0; i < 4; i++)
              if (st_x[i] >= 0 && st_x[i] < MW && st_y[i] < e_b[st_x[i]]) e_b[st_x[i]] = st_y[i];
            n_fig    = (m_fig + 1) % 3;
            n_pieces = (m_pieces + 1) % 65536;
            n_phase  = P_SPAWN;
          end
          default: e_go = 1'b1;
        endcase
      end
      for (int c = 0; c < MW; c++) e_nb[(MW-1-c)*W +: W] = W'(e_b[c]);
      for (int i = 0; i < 4; i++) begin
        e_nx[(3-i)*W +: W] = W'(e_x[i]);
        e_ny[(3-i)*W +: W] = W'(e_y[i]);
      end
      chk("write_reg", write_reg, e_wr);
      chk("is_load_fig", is_load_fig, e_ld);
      chk("cmd_ack", cmd_ack, e_ack);
      chk("game_over", game_over, e_go);
      if (!rst) begin
        chk("figure", figure, m_fig);
        chk("pieces", pieces, m_pieces);
        chk("new_border", new_border, e_nb);
        chk("new_rho_x", new_rho_x, e_nx);
        chk("new_rho_y", new_rho_y, e_ny);
        if (cmd_ack) ack_cnt++;
        if (write_reg) wr_cnt++;
        if (is_load_fig) ld_cnt++;
      end
      m_phase = n_phase; m_req = n_req; m_fig = n_fig; m_pieces = n_pieces;
      m_valid = 1'b1;
    end
  end

  task automatic wait_phase(input string what, input int ph);
    int n = 0;
    while (m_phase != ph && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (m_phase != ph) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: timeout, phase %0d required %0d", what, m_phase, ph);
    end
  endtask

  task automatic pulse(input bit t, input bit l, input bit r);
    @(posedge clk); #1;
    tick = t; cmd_left = l; cmd_right = r;
    @(posedge clk); #1;
    tick = 1'b0; cmd_left = 1'b0; cmd_right = 1'b0;
  endtask

  task automatic settle(input string what);
    wait_phase(what, P_READY);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_game_over", game_over, 0);
    chk("rst_pieces", pieces, 0);
    chk("rst_figure", figure, 0);
    rst = 1'b0;
    wait_phase("spawn_T", P_READY);
    chk_cells("spawn_T", 0, 1, 2, 1, 0, 0, 0, 1);

    a0 = ack_cnt; w0 = wr_cnt;
    pulse(0, 1, 0);
    settle("left_wall");
    chk("left_ack", ack_cnt - a0, 1);
    chk("left_write", wr_cnt - w0, 0);
    chk_cells("left_wall", 0, 1, 2, 1, 0, 0, 0, 1);

    for (int k = 0; k < 7; k++) begin
      pulse(0, 0, 1);
      wait_phase("right_step", P_READY);
    end
    @(posedge clk); #1;
    chk_cells("right_7", 7, 8, 9, 8, 0, 0, 0, 1);
    a0 = ack_cnt; w0 = wr_cnt;
    pulse(0, 0, 1);
    settle("right_8");
    chk("right8_ack", ack_cnt - a0, 1);
    chk("right8_write", wr_cnt - w0, 0);
    chk_cells("right_8", 7, 8, 9, 8, 0, 0, 0, 1);

    a0 = ack_cnt; w0 = wr_cnt;
    pulse(1, 1, 0);
    settle("simul");
    chk("simul_ack", ack_cnt - a0, 1);
    chk("simul_write", wr_cnt - w0, 1);
    chk_cells("simul", 7, 8, 9, 8, 1, 1, 1, 2);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_phase("respawn_T", P_READY);
    for (int k = 0; k < 4; k++) begin
      pulse(1, 0, 0);
      wait_phase("t_drop", P_READY);
    end
    @(posedge clk); #1;
    chk_cells("t_drop4", 0, 1, 2, 1, 4, 4, 4, 5);
    l0 = ld_cnt;
    pulse(1, 0, 0);
    wait_phase("land_T", P_READY);
    for (int c = 0; c < MW; c++)
      chk($sformatf("land_T_border%0d", c), st_border[c], (c < 3) ? 4 : 6);
    chk("land_T_pieces", pieces, 1);
    chk("land_T_figure", figure, 1);
    chk("land_T_spawn", ld_cnt - l0, 1);
    chk_cells("spawn_Q", 0, 1, 0, 0, 0, 0, 1, 2);

    pulse(1, 0, 0);
    settle("q_drop");
    chk_cells("q_drop", 0, 1, 0, 0, 1, 1, 2, 3);
    pulse(1, 0, 0);
    wait_phase("game_over", P_OVER);
    @(posedge clk); #1;
    chk("over_flag", game_over, 1);
    chk("over_pieces", pieces, 2);
    chk("over_figure", figure, 2);
    chk("over_border0", st_border[0], 1);
    chk("over_border1", st_border[1], 1);
    chk("over_border2", st_border[2], 4);
    chk_cells("spawn_I", 0, 0, 0, 0, 0, 1, 2, 3);
    a0 = ack_cnt; w0 = wr_cnt;
    pulse(1, 0, 0);
    pulse(0, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("over_ignore_ack", ack_cnt - a0, 0);
    chk("over_ignore_write", wr_cnt - w0, 0);
    chk("over_sticky", game_over, 1);

    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_clears_over", game_over, 0);
    rst = 1'b0;
    wait_phase("restart", P_READY);
    chk("restart_pieces", pieces, 0);
    chk("restart_figure", figure, 0);
    chk_cells("restart_T", 0, 1, 2, 1, 0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
